// File: rtl/pass_rom_arbiter.sv
// Round-robin arbiter that shares one registered-read password ROM and assembles 4 nibbles into a 16-bit word.
// Latency: ack 1 cycle after the request is sampled, done 4*(ROM_LAT+2) cycles later; requests wait while busy.
module pass_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ROM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*5-1:0] base_addr,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [15:0]          rdata,
  output logic [4:0]           rom_addr,
  input  logic [3:0]           rom_q,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      gnt_idx_q;
  logic [1:0]         nib_q;
  logic [2:0]         wcnt_q;
  logic [4:0]         cur_addr_q;
  logic [15:0]        shreg_q;
  logic [15:0]        rdata_q;
  logic [4:0]         rom_addr_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] done_q;

  logic [4:0]         base_arr [NUM_REQ];
  logic               gnt_vld_d;
  logic [IW-1:0]      gnt_idx_d;
  logic [IW-1:0]      idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      base_arr[i] = base_addr[5*i +: 5];
    end
  end

  // Search starts just past the last winner, so the last winner ranks lowest.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_idx_d = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_vld_d && req[idx]) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= IW'(NUM_REQ-1);
      gnt_idx_q  <= '0;
      nib_q      <= '0;
      wcnt_q     <= '0;
      cur_addr_q <= '0;
      shreg_q    <= '0;
      rdata_q    <= '0;
      rom_addr_q <= '0;
      ack_q      <= '0;
      done_q     <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld_d) begin
            cur_addr_q <= base_arr[gnt_idx_d];
            gnt_idx_q  <= gnt_idx_d;
            ptr_q      <= gnt_idx_d;
            nib_q      <= '0;
            ack_q      <= NUM_REQ'(1) << gnt_idx_d;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rom_addr_q <= cur_addr_q;
          wcnt_q     <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt_q == 3'(ROM_LAT-1)) begin
            state_q <= S_CAPTURE;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        S_CAPTURE: begin
          shreg_q    <= {shreg_q[11:0], rom_q};
          cur_addr_q <= cur_addr_q + 5'd1;
          if (nib_q == 2'd3) begin
            // Last nibble goes straight into rdata so it is valid alongside done.
            rdata_q <= {shreg_q[11:0], rom_q};
            done_q  <= NUM_REQ'(1) << gnt_idx_q;
            state_q <= S_DONE;
          end else begin
            nib_q   <= nib_q + 2'd1;
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign rom_addr = rom_addr_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_pass_rom_arbiter.sv
// Directed bench for pass_rom_arbiter: registered ROM model, event logs, hand-computed expectations.
module tb_pass_rom_arbiter;
  localparam int NR = 4;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*5-1:0] base_addr = '0;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   done;
  logic [15:0]     rdata;
  logic [4:0]      rom_addr;
  logic [3:0]      rom_q = '0;
  logic            busy;

  logic [3:0]      mem [32];
  logic [NR-1:0]   hold = '0;

  pass_rom_arbiter #(.NUM_REQ(NR), .ROM_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req(req), .base_addr(base_addr),
    .ack(ack), .done(done), .rdata(rdata), .rom_addr(rom_addr),
    .rom_q(rom_q), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= mem[rom_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;

  int          ack_idx[$];
  int          ack_cyc[$];
  int          done_idx[$];
  int          done_cyc[$];
  logic [15:0] done_dat[$];
  int          addr_val[$];
  int          addr_cyc[$];
  logic [4:0]  prev_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ack != '0) begin
      check("ack_onehot", $countones(ack), 1);
      ack_idx.push_back(oh_idx(ack));
      ack_cyc.push_back(cyc);
    end
    if (done != '0) begin
      check("done_onehot", $countones(done), 1);
      done_idx.push_back(oh_idx(done));
      done_cyc.push_back(cyc);
      done_dat.push_back(rdata);
    end
    if (rom_addr !== prev_addr) begin
      addr_val.push_back(int'(rom_addr));
      addr_cyc.push_back(cyc);
      prev_addr = rom_addr;
    end
  end

  // One cycle step; requesters drop req once acked unless told to hold it.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (ack[i] && !hold[i]) req[i] = 1'b0;
  endtask

  task automatic clear_logs();
    ack_idx.delete(); ack_cyc.delete();
    done_idx.delete(); done_cyc.delete(); done_dat.delete();
    addr_val.delete(); addr_cyc.delete();
  endtask

  task automatic do_reset();
    req = '0;
    hold = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_idx.size() < n; i++) tick();
    if (done_idx.size() < n) check("timeout_done", done_idx.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 4'h0;
    mem[4] = 4'hA; mem[5] = 4'hB; mem[6] = 4'hC; mem[7] = 4'hD;
    mem[8] = 4'h1; mem[9] = 4'h2; mem[10] = 4'h3; mem[11] = 4'h4;
    mem[12] = 4'h5; mem[13] = 4'h6; mem[14] = 4'h7; mem[15] = 4'h8;
    mem[16] = 4'h9; mem[17] = 4'h8; mem[18] = 4'h7; mem[19] = 4'h6;
    mem[20] = 4'hC; mem[21] = 4'h0; mem[22] = 4'hD; mem[23] = 4'hE;
    mem[30] = 4'h1; mem[31] = 4'h2; mem[0] = 4'h3; mem[1] = 4'h4;

    // Reset state
    tick();
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick();
    clear_logs();

    // Single requester
    base_addr[5*1 +: 5] = 5'd4;
    t0 = cyc;
    req[1] = 1'b1;
    wait_done(1, 40);
    check("single_ack_idx", ack_idx[0], 1);
    check("single_ack_cyc", ack_cyc[0] - t0, 1);
    check("single_done_idx", done_idx[0], 1);
    check("single_done_cyc", done_cyc[0] - t0, 17);
    check("single_rdata", done_dat[0], 16'hABCD);
    check("single_addr_cnt", addr_val.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("single_addr_val", addr_val[k], 4 + k);
      check("single_addr_cyc", addr_cyc[k] - t0, 2 + 4*k);
    end
    tick();
    check("single_idle_busy", busy, 0);
    check("single_rdata_hold", rdata, 16'hABCD);
    check("single_done_low", done, 0);

    // Simultaneous requests after reset
    do_reset();
    base_addr[5*0 +: 5] = 5'd8;
    base_addr[5*2 +: 5] = 5'd12;
    req = 4'b0101;
    wait_done(2, 60);
    check("simul_first", ack_idx[0], 0);
    check("simul_second", ack_idx[1], 2);
    check("simul_gap", ack_cyc[1] - done_cyc[0], 2);
    check("simul_dat0", done_dat[0], 16'h1234);
    check("simul_dat2", done_dat[1], 16'h5678);

    // Fairness with all requests held
    do_reset();
    base_addr[5*1 +: 5] = 5'd4;
    base_addr[5*3 +: 5] = 5'd16;
    hold = 4'hF;
    req = 4'hF;
    wait_done(6, 150);
    req = '0;
    hold = '0;
    for (int k = 0; k < 6; k++) check("fair_order", done_idx[k], k % 4);
    for (int k = 1; k < 6; k++) check("fair_period", done_cyc[k] - done_cyc[k-1], 18);
    check("fair_dat3", done_dat[3], 16'h9876);
    wait_idle(40);

    // Address wrap
    do_reset();
    base_addr[5*0 +: 5] = 5'd30;
    req[0] = 1'b1;
    wait_done(1, 40);
    check("wrap_addr_cnt", addr_val.size(), 4);
    check("wrap_addr0", addr_val[0], 30);
    check("wrap_addr1", addr_val[1], 31);
    check("wrap_addr2", addr_val[2], 0);
    check("wrap_addr3", addr_val[3], 1);
    check("wrap_rdata", done_dat[0], 16'h1234);
    tick();

    // Reset mid-fetch: second WAIT of nibble index 2 is cycle 11
    clear_logs();
    base_addr[5*1 +: 5] = 5'd16;
    req[1] = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check("midrst_pre_addr", rom_addr, 18);
    check("midrst_pre_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_done", done, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("midrst_no_done", done_idx.size(), 0);
    clear_logs();
    base_addr[5*0 +: 5] = 5'd8;
    base_addr[5*3 +: 5] = 5'd20;
    req = 4'b1001;
    wait_done(2, 60);
    check("midrst_ptr_first", ack_idx[0], 0);
    check("midrst_req3", ack_idx[1], 3);
    check("midrst_req3_dat", done_dat[1], 16'hC0DE);
    tick();

    // Held request with a late competitor
    clear_logs();
    base_addr[5*1 +: 5] = 5'd8;
    base_addr[5*2 +: 5] = 5'd12;
    hold[2] = 1'b1;
    req[2] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    req[1] = 1'b1;
    wait_done(3, 80);
    req = '0;
    hold = '0;
    check("held_g0", ack_idx[0], 2);
    check("held_g1", ack_idx[1], 1);
    check("held_g2", ack_idx[2], 2);
    check("held_dat1", done_dat[1], 16'h1234);
    check("held_dat2", done_dat[2], 16'h5678);
    wait_idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pass_rom_arbiter.md
# pass_rom_arbiter

Shares the single password ROM (32 words × 4 bits, registered read) among up to `NUM_REQ` password-check controllers, e.g. one per user station. Each requester asks for a 16-bit password starting at a 5-bit base address. The arbiter grants one requester at a time in round-robin order. It then sequences four consecutive ROM reads and returns the assembled word with a one-cycle `done` pulse. It sits between the per-station password controllers and the ROM instance, and owns the ROM address bus exclusively.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ROM_LAT`, 2: wait cycles between driving `rom_addr` and sampling `rom_q` (1..4).

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset is asynchronous and active-low.
- `req` in `NUM_REQ`: per-requester fetch request, level.
- `base_addr` in `NUM_REQ*5`: base ROM address, requester i occupies bits [5i+4:5i].
- `ack` out `NUM_REQ`: one-hot, one-cycle grant pulse; the base address has been captured.
- `done` out `NUM_REQ`: one-hot, one-cycle completion pulse, coincident with valid `rdata`.
- `rdata` out 16: assembled password, first-read nibble in [15:12].
- `rom_addr` out 5: registered address to the ROM.
- `rom_q` in 4: ROM data output.
- `busy` out 1: high in every state except IDLE.

## Operation
- States are IDLE, ISSUE, WAIT, CAPTURE and DONE.
- IDLE:
  - If any `req` bit is high, select winner i by round-robin. Search starts at `(ptr+1) mod NUM_REQ`; `ptr` holds the index of the last winner.
  - On the selection edge: latch `base_addr[i]` into `cur_addr`, set `gnt_idx=i`, `ptr=i`, `nib=0`, and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: `rom_addr <= cur_addr`, clear the wait counter, go to WAIT. `ack[gnt_idx]` is high only in the first ISSUE cycle (`nib==0`).
- WAIT: count `ROM_LAT` cycles, then go to CAPTURE.
- CAPTURE:
  - Update the shift register: `shreg <= {shreg[11:0], rom_q}`.
  - Advance `cur_addr <= cur_addr+1`. The 5-bit add wraps, so 31 is followed by 0.
  - If `nib==3`, go to DONE; otherwise increment `nib` and go to ISSUE.
- DONE: `rdata <= shreg` is registered on entry, so it is valid during DONE. `done[gnt_idx]` is high for that cycle. Return to IDLE.
- `rdata` holds its value until the next DONE.
- Requester rule: hold `req` until `ack`, then drop it. Requests that arrive while busy wait; they are not lost while `req` stays high.
- If `req[i]` is still high in IDLE after its own `done`, it is a new request. Round-robin still places it last behind other pending requesters.
- `req` and `base_addr` changes during a transaction are ignored; the address was latched at grant.
- Reset values:
  - State IDLE; `ptr = NUM_REQ-1`, so requester 0 has highest priority after reset.
  - `ack=0`, `done=0`, `rdata=0`, `rom_addr=0`, `busy=0`, `shreg=0`, `nib=0`.
- Reset asserted mid-transaction aborts immediately. No `done` is issued, and the requester must re-request.
- Only one requester is ever served at a time; `ack` and `done` are never multi-hot.

## Timing
- Let E0 be the edge at which IDLE samples `req`.
  - `ack` is high in cycle 1, after E0.
  - Each nibble takes `ROM_LAT+2` cycles: ISSUE, `ROM_LAT`×WAIT, CAPTURE.
  - `done` is high in cycle `1 + 4*(ROM_LAT+2)`; with the default this is cycle 17.
  - IDLE follows one cycle later. Service period is `4*(ROM_LAT+2)+2` cycles, 18 by default.
- `rom_addr` changes only on the edge leaving ISSUE. `rom_q` is sampled in CAPTURE, `ROM_LAT+1` cycles after `rom_addr` updates.
- No combinational path from `req` to `ack`, `done` or `rom_addr`.

## Test plan
- Single requester: req[1]=1, base=4, ROM[4..7]=A,B,C,D. Required: ack[1] in cycle 1, rom_addr=4,5,6,7, done[1] in cycle 17, rdata=16'hABCD.
- Simultaneous requests after reset: req[0] and req[2] both high. Required: requester 0 served first, then requester 2, with ack[2] in the IDLE+1 cycle after done[0].
- Fairness: all four req held high continuously. Required: grant order 0,1,2,3,0,1; each done pulse exactly 18 cycles apart.
- Address wrap: base=30, ROM[30]=1, ROM[31]=2, ROM[0]=3, ROM[1]=4. Required: rom_addr sequence 30,31,0,1; rdata=16'h1234.
- Reset mid-fetch: assert rst=0 during the second WAIT of nibble 2. Required: all outputs are 0 immediately, no done follows, and a subsequent req[3] is served normally with requester-0-first pointer state.
- Held request: req[2] remains high after done[2], and req[1] rises during the transaction. Required: requester 1 is granted next, then requester 2 again.
